// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared instruction-memory constants and loader state type
//
// Purpose: constants shared between the instruction RAM (imem) and its
// loader, plus the loader FSM state encoding.
package imem_pkg;

  // Word-address width of the instruction RAM (64 words).
  localparam int IMEM_ADDR_W = 6;
  // Instruction width; a whole number of bytes.
  localparam int IMEM_WORD_W = 32;
  // Bytes per instruction word.
  localparam int IMEM_BPW    = IMEM_WORD_W / 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT,
    LD_DATA,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a byte stream big-endian into instruction words
//
// Purpose: shifts each accepted byte into a WORD_W register (first byte ends
// up in the most significant position) and pulses word_valid_o for one cycle
// after every WORD_W/8-th byte.
//
// Ports:
//   clk_i         system clock
//   resetn_i      synchronous active-low reset
//   clr_i         restart byte counting at the first byte of a word
//   byte_en_i     byte_i is accepted this cycle
//   byte_i        stream byte
//   last_byte_o   the byte accepted this cycle completes a word
//   word_o        assembled word (valid while word_valid_o is high)
//   word_valid_o  one-cycle pulse, cycle after the word's last byte
module byte_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic              last_byte_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int BPW   = WORD_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;

  logic at_last;
  assign at_last     = (idx_q == IDX_W'(BPW - 1));
  assign last_byte_o = byte_en_i && at_last;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clr_i) begin
        idx_q <= '0;
      end else if (byte_en_i) begin
        word_q <= {word_q[WORD_W-9:0], byte_i};
        if (at_last) begin
          idx_q   <= '0;
          valid_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction RAM
//
// Purpose: receives "count, data bytes, xor checksum" over a byte link,
// writes each big-endian word into the instruction RAM, and keeps the CPU in
// reset until a load finishes with a matching checksum.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   start       one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   byte_valid  byte_data valid this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   we          RAM write enable (one-cycle pulse)
//   waddr       RAM word address
//   wdata       RAM write data
//   cpu_hold    processor held in reset while high
//   done        load completed, checksum matched
//   err         checksum mismatch
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  loader_state_t state_q, state_d;
  // One extra bit so a full RAM (count byte with zero low bits) fits.
  logic [ADDR_W:0]   words_left_q, words_left_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        acc_q, acc_d;

  logic              xfer;
  logic              packer_clr;
  logic              packer_en;
  logic              last_byte;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [ADDR_W-1:0] cnt_low;

  assign byte_ready = (state_q == LD_COUNT) || (state_q == LD_DATA) ||
                      (state_q == LD_CHECK);
  assign xfer       = byte_valid && byte_ready;
  assign packer_clr = (state_q == LD_COUNT) && xfer;
  assign packer_en  = (state_q == LD_DATA) && xfer;
  assign cnt_low    = byte_data[ADDR_W-1:0];

  byte_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk_i        (clk),
    .resetn_i     (reset),
    .clr_i        (packer_clr),
    .byte_en_i    (packer_en),
    .byte_i       (byte_data),
    .last_byte_o  (last_byte),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= LD_IDLE;
      words_left_q <= '0;
      waddr_q      <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      waddr_q      <= waddr_d;
      acc_q        <= acc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    waddr_d      = waddr_q;
    acc_d        = acc_q;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) state_d = LD_COUNT;
      end
      LD_COUNT: begin
        if (xfer) begin
          // Zero low bits encode a full RAM: {1, 0...0}.
          words_left_d = {cnt_low == '0, cnt_low};
          waddr_d      = '0;
          acc_d        = '0;
          state_d      = LD_DATA;
        end
      end
      LD_DATA: begin
        if (xfer) begin
          acc_d = acc_q ^ byte_data;
          // Leave DATA as the last word completes so the following byte,
          // which may arrive during the write cycle, is taken as checksum.
          // The previous word's write has always retired by now, so
          // words_left_q still counts this word.
          if (last_byte && (words_left_q == (ADDR_W+1)'(1))) begin
            state_d = LD_CHECK;
          end
        end
      end
      LD_CHECK: begin
        if (xfer) begin
          state_d = (byte_data == acc_q) ? LD_DONE : LD_ERROR;
        end
      end
      default: state_d = LD_IDLE;
    endcase

    // Address and remaining count advance with each write pulse; the
    // address wraps to 0 only after a full 64-word load.
    if (word_valid) begin
      waddr_d      = waddr_q + ADDR_W'(1);
      words_left_d = words_left_q - (ADDR_W+1)'(1);
    end
  end

  assign we       = word_valid;
  assign waddr    = waddr_q;
  assign wdata    = word;
  assign cpu_hold = (state_q != LD_DONE);
  assign done     = (state_q == LD_DONE);
  assign err      = (state_q == LD_ERROR);

endmodule
